// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding word-bus access. A load completes 2 cycles after the request at best; errors complete in 1.
// Stall holds the pipeline while the request is pending; each result or error is reported in a one-cycle DONE state.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        TimeoutErr,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusWStrb,
    input  logic        BusAck,
    input  logic [31:0] BusRData
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;

    logic        f3_ok;
    logic        misaligned;
    logic        illegal;
    logic [31:0] st_wdata;
    logic [3:0]  st_strb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        f3_ok = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default: f3_ok = 1'b0;
        endcase
    end

    assign misaligned = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                        ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));

    // Unsigned widths only exist for loads, so a store using them is rejected.
    assign illegal = (MemRead && MemWrite) || !f3_ok || misaligned || (MemWrite && Funct3[2]);

    always_comb begin
        st_wdata = WriteData;
        st_strb  = 4'b1111;
        case (Funct3[1:0])
            2'b00: begin
                st_wdata = {4{WriteData[7:0]}};
                st_strb  = 4'b0001 << ALUResult[1:0];
            end
            2'b01: begin
                st_wdata = {2{WriteData[15:0]}};
                st_strb  = 4'b0011 << ALUResult[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = BusRData[7:0];
        case (lane_q)
            2'd1:    ld_byte = BusRData[15:8];
            2'd2:    ld_byte = BusRData[23:16];
            2'd3:    ld_byte = BusRData[31:24];
            default: ld_byte = BusRData[7:0];
        endcase
        ld_half = lane_q[1] ? BusRData[31:16] : BusRData[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = BusRData;
        endcase
    end

    assign Stall = ((state == IDLE) && (MemRead || MemWrite)) || (state == REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
            BusReq     <= 1'b0;
            BusWe      <= 1'b0;
            BusAddr    <= '0;
            BusWData   <= '0;
            BusWStrb   <= '0;
            ReadData   <= '0;
            AccessErr  <= 1'b0;
            TimeoutErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        if (illegal) begin
                            AccessErr <= 1'b1;
                            ReadData  <= '0;
                            state     <= DONE;
                        end else begin
                            BusReq   <= 1'b1;
                            BusWe    <= MemWrite;
                            BusAddr  <= {ALUResult[31:2], 2'b00};
                            BusWData <= MemWrite ? st_wdata : 32'd0;
                            BusWStrb <= MemWrite ? st_strb : 4'd0;
                            f3_q     <= Funct3;
                            lane_q   <= ALUResult[1:0];
                            wait_cnt <= '0;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the last permitted cycle still completes normally.
                    if (BusAck) begin
                        BusReq <= 1'b0;
                        if (!BusWe) ReadData <= ld_ext;
                        state  <= DONE;
                    end else if (wait_cnt == TMO_LAST) begin
                        BusReq     <= 1'b0;
                        TimeoutErr <= 1'b1;
                        ReadData   <= '0;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    AccessErr  <= 1'b0;
                    TimeoutErr <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting for BusAck before abort (1..255).
REQ-002 SHALL have one clock and asynchronous active-high reset; ports below, clock and reset first.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemRead  input  1  load request from execute stage.
REQ-006 MemWrite  input  1  store request from execute stage.
REQ-007 Funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 ALUResult  input  32  effective byte address from ALU.
REQ-009 WriteData  input  32  store source register value.
REQ-010 ReadData  output  32  extended load result, registered.
REQ-011 Stall  output  1  holds core pipeline while access is outstanding.
REQ-012 AccessErr  output  1  one-cycle pulse: misaligned, illegal Funct3, or MemRead&MemWrite.
REQ-013 TimeoutErr  output  1  one-cycle pulse: BusAck not received within TIMEOUT cycles.
REQ-014 BusReq  output  1  bus request, registered.
REQ-015 BusWe  output  1  1 = write, 0 = read.
REQ-016 BusAddr  output  32  word address, {addr[31:2],2'b00}.
REQ-017 BusWData  output  32  lane-replicated store data.
REQ-018 BusWStrb  output  4  byte-lane write strobes (0000 on reads).
REQ-019 BusAck  input  1  single-cycle completion from memory.
REQ-020 BusRData  input  32  read word, valid when BusAck=1.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, DONE.
REQ-022 IDLE: on MemRead^MemWrite with legal, aligned access -> latch address/data/Funct3, drive bus regs, BusReq=1, go REQ.
REQ-023 IDLE: on illegal access (misaligned H/W, Funct3 in {011,110,111}, store Funct3 in {100,101}, or MemRead&MemWrite) -> no bus cycle, AccessErr=1 and ReadData=0 in DONE, go DONE.
REQ-024 REQ: BusReq and all bus outputs held stable until BusAck; on BusAck -> BusReq=0, load ReadData (reads), go DONE.
REQ-025 REQ: 8-bit wait counter increments each cycle without BusAck; on reaching TIMEOUT -> BusReq=0, TimeoutErr=1 in DONE, ReadData=0, go DONE; BusAck in the same cycle as timeout wins (normal completion).
REQ-026 DONE: lasts exactly one cycle, Stall=0, error pulses asserted here only; then IDLE; new requests ignored while in DONE.
REQ-027 Stall SHALL be combinational = (IDLE & (MemRead|MemWrite)) | REQ.
REQ-028 Minimum latency: request in IDLE cycle N, BusAck in N+1, ReadData valid and Stall=0 in N+2.
REQ-029 Store lanes: SB BusWData={4{WriteData[7:0]}}, BusWStrb=0001<<addr[1:0]; SH {2{WriteData[15:0]}}, 0011<<addr[1:0]; SW WriteData, 1111.
REQ-030 Load extract: byte at lane addr[1:0], half at lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-031 Misaligned = H with addr[0]=1, or W with addr[1:0]!=00; B never misaligned.
REQ-032 ReadData SHALL hold its value until the next completed load or error.

Reset
REQ-033 reset SHALL asynchronously force IDLE, counter=0, BusReq=0, BusWe=0, BusAddr=0, BusWData=0, BusWStrb=0, ReadData=0, AccessErr=0, TimeoutErr=0.
REQ-034 reset during REQ SHALL drop BusReq immediately and discard the access; a late BusAck is ignored in IDLE.

Verification
REQ-035 SW addr 0x100, WriteData 0xDEADBEEF, ack after 3 cycles -> BusAddr 0x100, BusWStrb 1111, BusWe=1, Stall high 4 cycles, no errors.
REQ-036 LB addr 0x103, BusRData 0x80FF_FF7F -> ReadData 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-037 SH addr 0x0A, WriteData 0x1234ABCD -> BusAddr 0x08, BusWData 0xABCDABCD, BusWStrb 1100.
REQ-038 LW addr 0x101 -> no BusReq, AccessErr pulse one cycle, ReadData 0, Stall released after 1 cycle.
REQ-039 LW with BusAck never asserted, TIMEOUT=4 -> BusReq high 4 cycles, then TimeoutErr pulse, ReadData 0.
REQ-040 reset asserted mid-REQ, then BusAck pulse -> BusReq 0 at once, state IDLE, ReadData unchanged at 0, no error pulses.
